// File: rtl/ntt_pointwise_mul.sv
// Pointwise Goldilocks modular multiplier: reads A[i], B[i] from BRAM, writes A[i]*B[i] mod Q to C[i].
// Optional macro PWM_CANON_CHECK_EN folds non-canonical operands (>= Q) and raises a sticky err flag.
module ntt_pointwise_mul #(
   parameter int N      = 64,
   parameter int A_BASE = 64,
   parameter int B_BASE = 128,
   parameter int C_BASE = 192
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [11:0] BRAM_addr,
   output logic        BRAM_clk,
   output logic [63:0] BRAM_din,
   input  logic [63:0] BRAM_dout,
   output logic        BRAM_en,
   output logic        BRAM_rst,
   output logic        BRAM_we
);
   localparam logic [63:0] Q   = 64'hFFFF_FFFF_0000_0001;
   localparam logic [63:0] EPS = 64'h0000_0000_FFFF_FFFF;  // 2^64 mod Q

   typedef enum logic [2:0] {IDLE, RD_A, RD_B, MUL, RED, WR, DONE} state_t;

   state_t         state;
   logic [7:0]     idx;
   logic [63:0]    a_reg;
   logic [127:0]   prod_reg;
   logic [63:0]    op;
   logic [63:0]    res;

   assign BRAM_clk = clk;
   assign BRAM_rst = rst;

   function automatic logic [11:0] byte_addr(input int base, input logic [7:0] i);
      return 12'((base + int'(i)) * 4);
   endfunction

`ifdef PWM_CANON_CHECK_EN
   logic err_reg;
   assign op  = (BRAM_dout >= Q) ? (BRAM_dout - Q) : BRAM_dout;
   assign err = err_reg;

   always_ff @(posedge clk) begin
      if (rst)
         err_reg <= 1'b0;
      else if ((state == MUL || state == RED) && (BRAM_dout >= Q))
         err_reg <= 1'b1;
   end
`else
   assign op  = BRAM_dout;
   assign err = 1'b0;
`endif

   // Goldilocks reduction of the registered 128-bit product.
   logic [31:0] h3, h2;
   logic [63:0] lo;
   logic [64:0] diff, sum;
   logic [63:0] t0, t1, t2;

   assign lo = prod_reg[63:0];
   assign h2 = prod_reg[95:64];
   assign h3 = prod_reg[127:96];

   always_comb begin
      diff = {1'b0, lo} - {33'b0, h3};
      t0   = diff[63:0];
      if (diff[64])
         t0 = t0 - EPS;
      t1  = {h2, 32'b0} - {32'b0, h2};
      sum = {1'b0, t0} + {1'b0, t1};
      t2  = sum[63:0];
      if (sum[64])
         t2 = t2 + EPS;
      res = (t2 >= Q) ? (t2 - Q) : t2;
   end

   // Bus outputs are registered from the current state, so they reach the BRAM one
   // cycle behind it; operands therefore arrive on BRAM_dout during MUL and RED.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         a_reg     <= '0;
         prod_reg  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         BRAM_addr <= '0;
         BRAM_din  <= '0;
         BRAM_en   <= 1'b0;
         BRAM_we   <= 1'b0;
      end else begin
         done      <= 1'b0;
         BRAM_we   <= 1'b0;
         BRAM_en   <= 1'b0;
         BRAM_addr <= '0;
         busy      <= (state != IDLE);
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RD_A;
                  idx   <= '0;
                  busy  <= 1'b1;
               end
            end
            RD_A: begin
               BRAM_en   <= 1'b1;
               BRAM_addr <= byte_addr(A_BASE, idx);
               state     <= RD_B;
            end
            RD_B: begin
               BRAM_en   <= 1'b1;
               BRAM_addr <= byte_addr(B_BASE, idx);
               state     <= MUL;
            end
            MUL: begin
               BRAM_en <= 1'b1;
               a_reg   <= op;
               state   <= RED;
            end
            RED: begin
               BRAM_en  <= 1'b1;
               prod_reg <= {64'b0, a_reg} * {64'b0, op};
               state    <= WR;
            end
            WR: begin
               BRAM_en   <= 1'b1;
               BRAM_we   <= 1'b1;
               BRAM_addr <= byte_addr(C_BASE, idx);
               BRAM_din  <= res;
               if (idx == 8'(N - 1)) begin
                  state <= DONE;
               end else begin
                  idx   <= idx + 8'd1;
                  state <= RD_A;
               end
            end
            DONE: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
